// File: rtl/vga_text_console.sv
// Terminal-style writer for the 40x20 VGA text RAM: prints, moves the cursor, scrolls and clears.
// RAM port is address phase then data phase; char_ready drops while any RAM sequence runs.
module vga_text_console #(
  parameter int          COLS  = 40,
  parameter int          ROWS  = 20,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [9:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic [5:0] cursor_x,
  output logic [4:0] cursor_y,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, PUT_A, PUT_D, SCR_RD, SCR_MV, SCR_WR, CLR_A, CLR_D} state_t;

  localparam logic [9:0] COLS_W = 10'(COLS);
  localparam logic [9:0] LAST   = 10'(COLS * ROWS - 1);
  localparam logic [9:0] TAIL   = 10'((ROWS - 1) * COLS);

  state_t     state_q, state_d;
  logic [5:0] cx_q, cx_d;
  logic [4:0] cy_q, cy_d;
  logic [9:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic [9:0] idx_q, idx_d;
  logic [7:0] char_q, char_d;
  logic       adv_q, adv_d;
  logic       ff_q, ff_d;
  logic       ready_q, busy_q;
  logic [9:0] cur_idx;

  assign cur_idx = 10'(cy_q) * COLS_W + 10'(cx_q);

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    idx_d   = idx_q;
    char_d  = char_q;
    adv_d   = adv_q;
    ff_d    = ff_q;
    case (state_q)
      IDLE: if (char_valid) begin
        case (char_in)
          8'h0A: begin
            cx_d = '0;
            if (cy_q < 5'(ROWS - 1)) cy_d = cy_q + 5'd1;
            else begin
              state_d = SCR_RD;
              idx_d   = COLS_W;
              addr_d  = COLS_W;
            end
          end
          8'h0D: cx_d = '0;
          8'h08: if (cx_q != '0) begin
            cx_d    = cx_q - 6'd1;
            addr_d  = cur_idx - 10'd1;
            char_d  = BLANK;
            adv_d   = 1'b0;
            state_d = PUT_A;
          end
          8'h0C: begin
            ff_d    = 1'b1;
            idx_d   = '0;
            addr_d  = '0;
            state_d = CLR_A;
          end
          default: begin
            char_d  = char_in;
            addr_d  = cur_idx;
            adv_d   = 1'b1;
            state_d = PUT_A;
          end
        endcase
      end
      PUT_A: begin
        state_d = PUT_D;
        we_d    = 1'b1;
        wdata_d = char_q;
      end
      PUT_D: begin
        state_d = IDLE;
        if (adv_q) begin
          if (cx_q == 6'(COLS - 1)) begin
            cx_d = '0;
            if (cy_q == 5'(ROWS - 1)) begin
              state_d = SCR_RD;
              idx_d   = COLS_W;
              addr_d  = COLS_W;
            end else begin
              cy_d = cy_q + 5'd1;
            end
          end else begin
            cx_d = cx_q + 6'd1;
          end
        end
      end
      SCR_RD: begin
        state_d = SCR_MV;
        addr_d  = idx_q - COLS_W;
      end
      SCR_MV: begin
        // Read data for cell idx arrives now; it becomes the write data one row up.
        state_d = SCR_WR;
        we_d    = 1'b1;
        wdata_d = mem_rdata;
      end
      SCR_WR: begin
        if (idx_q == LAST) begin
          state_d = CLR_A;
          ff_d    = 1'b0;
          idx_d   = TAIL;
          addr_d  = TAIL;
        end else begin
          state_d = SCR_RD;
          idx_d   = idx_q + 10'd1;
          addr_d  = idx_q + 10'd1;
        end
      end
      CLR_A: begin
        state_d = CLR_D;
        we_d    = 1'b1;
        wdata_d = BLANK;
      end
      CLR_D: begin
        if (idx_q == LAST) begin
          state_d = IDLE;
          if (ff_q) begin
            cx_d = '0;
            cy_d = '0;
          end
        end else begin
          state_d = CLR_A;
          idx_d   = idx_q + 10'd1;
          addr_d  = idx_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      char_q  <= '0;
      adv_q   <= 1'b0;
      ff_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      adv_q   <= adv_d;
      ff_q    <= ff_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
    end
  end

  // Masking with rst keeps a pending write from landing on the reset edge.
  assign char_ready = ready_q & ~rst;
  assign mem_we     = we_q & ~rst;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign cursor_x   = cx_q;
  assign cursor_y   = cy_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_vga_text_console.sv
// Bench for vga_text_console: behavioural text RAM, expected-write queue, per-scenario tasks.
module tb_vga_text_console;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_in = '0;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic [5:0] cursor_x;
  logic [4:0] cursor_y;
  logic       busy;

  vga_text_console dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid), .char_ready(char_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [1024];
  logic [9:0] addr_l = '0;
  logic       pre_en = 1'b0;
  logic [9:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  assign mem_rdata = ram[addr_l];

  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[addr_l] <= mem_wdata;
    addr_l <= mem_addr;
  end

  int n_pass = 0;
  int n_total = 0;
  int wr_cnt = 0;
  int mx = 0, my = 0;
  logic [17:0] exp_q [$];
  logic [7:0]  shadow [1024];

  function automatic void exp_write(input logic [9:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
    shadow[a] = d;
  endfunction

  function automatic void model_scroll();
    for (int i = 40; i < 800; i++) exp_write(10'(i - 40), shadow[i]);
    for (int i = 760; i < 800; i++) exp_write(10'(i), 8'h20);
  endfunction

  task automatic monitor();
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        wr_cnt++;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL wr_unexpected got addr=%0d data=%h, required no write", addr_l, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({addr_l, mem_wdata} !== e)
            $display("FAIL wr_order got addr=%0d data=%h, required addr=%0d data=%h",
                     addr_l, mem_wdata, e[17:8], e[7:0]);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    @(negedge clk);
    char_in = c;
    char_valid = 1'b1;
    n = 0;
    while (!char_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) begin
      n_total++;
      $display("FAIL send_timeout char=%h ready=%b required 1", c, char_ready);
    end
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 5000) begin
      cyc++;
      @(negedge clk);
    end
    if (busy) begin
      n_total++;
      $display("FAIL idle_timeout busy=%b after %0d cycles, required 0", busy, cyc);
    end
  endtask

  task automatic tb_char(input logic [7:0] c);
    int cyc;
    case (c)
      8'h0A: begin mx = 0; if (my < 19) my++; else model_scroll(); end
      8'h0D: mx = 0;
      8'h08: if (mx > 0) begin mx--; exp_write(10'(my * 40 + mx), 8'h20); end
      8'h0C: begin
        for (int i = 0; i < 800; i++) exp_write(10'(i), 8'h20);
        mx = 0; my = 0;
      end
      default: begin
        exp_write(10'(my * 40 + mx), c);
        if (mx == 39) begin
          mx = 0;
          if (my == 19) model_scroll(); else my++;
        end else mx++;
      end
    endcase
    send(c);
    wait_idle(cyc);
  endtask

  task automatic preload(input bit rnd);
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      pre_en = 1'b1;
      pre_addr = 10'(i);
      pre_data = rnd ? 8'($urandom_range(0, 255)) : 8'(i);
      shadow[i] = pre_data;
    end
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    char_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (char_ready !== 1'b0) $display("FAIL rst_ready got %b required 0", char_ready); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL rst_we got %b required 0", mem_we); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++; if (char_ready !== 1'b1) $display("FAIL post_rst_ready got %b required 1", char_ready); else n_pass++;
    n_total++; if ({busy, mem_we} !== 2'b00) $display("FAIL post_rst_busy_we got %b required 00", {busy, mem_we}); else n_pass++;
    n_total++; if ({mem_addr, mem_wdata} !== 18'd0) $display("FAIL post_rst_addr_data got %h required 0", {mem_addr, mem_wdata}); else n_pass++;
    n_total++; if ({cursor_x, cursor_y} !== 11'd0) $display("FAIL post_rst_cursor got (%0d,%0d) required (0,0)", cursor_x, cursor_y); else n_pass++;
    exp_q.delete();
    mx = 0; my = 0;
  endtask

  task automatic test_back_to_back();
    int lo;
    exp_write(10'd0, 8'h41);
    exp_write(10'd1, 8'h42);
    mx = 2;
    @(negedge clk);
    char_in = 8'h41;
    char_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      lo = 0;
      @(posedge clk);
      #1 char_in = 8'h42;
      if (k == 1) char_valid = 1'b0;
      @(negedge clk);
      while (!char_ready && lo < 10) begin
        lo++;
        @(negedge clk);
      end
      n_total++; if (lo != 2) $display("FAIL b2b_ready_low[%0d] got %0d cycles required 2", k, lo); else n_pass++;
    end
    n_total++; if ({cursor_x, cursor_y} !== {6'd2, 5'd0}) $display("FAIL b2b_cursor got (%0d,%0d) required (2,0)", cursor_x, cursor_y); else n_pass++;
    n_total++; if (wr_cnt != 2) $display("FAIL b2b_writes got %0d required 2", wr_cnt); else n_pass++;
    n_total++; if (ram[1] !== 8'h42) $display("FAIL b2b_ram1 got %h required 42", ram[1]); else n_pass++;
  endtask

  task automatic test_wrap_and_ctrl();
    int w0;
    tb_char(8'h0D);
    for (int i = 0; i < 5; i++) tb_char(8'h0A);
    for (int i = 0; i < 39; i++) tb_char(8'h78);
    n_total++; if ({cursor_x, cursor_y} !== {6'd39, 5'd5}) $display("FAIL setup_cursor got (%0d,%0d) required (39,5)", cursor_x, cursor_y); else n_pass++;
    tb_char(8'h5A);
    n_total++; if (ram[239] !== 8'h5A) $display("FAIL wrap_ram239 got %h required 5a", ram[239]); else n_pass++;
    n_total++; if ({cursor_x, cursor_y} !== {6'd0, 5'd6}) $display("FAIL wrap_cursor got (%0d,%0d) required (0,6)", cursor_x, cursor_y); else n_pass++;
    w0 = wr_cnt;
    tb_char(8'h0D);
    tb_char(8'h08);
    n_total++; if (wr_cnt != w0) $display("FAIL cr_bs_writes got %0d required 0", wr_cnt - w0); else n_pass++;
    n_total++; if ({cursor_x, cursor_y} !== {6'd0, 5'd6}) $display("FAIL cr_bs_cursor got (%0d,%0d) required (0,6)", cursor_x, cursor_y); else n_pass++;
    tb_char(8'h51);
    tb_char(8'h08);
    n_total++; if (ram[240] !== 8'h20) $display("FAIL bs_ram240 got %h required 20", ram[240]); else n_pass++;
    n_total++; if ({cursor_x, cursor_y} !== {6'd0, 5'd6}) $display("FAIL bs_cursor got (%0d,%0d) required (0,6)", cursor_x, cursor_y); else n_pass++;
  endtask

  task automatic test_scroll_lf();
    int cyc, bad;
    for (int i = 0; i < 13; i++) tb_char(8'h0A);
    for (int i = 0; i < 3; i++) tb_char(8'h61);
    n_total++; if ({cursor_x, cursor_y} !== {6'd3, 5'd19}) $display("FAIL lf_setup_cursor got (%0d,%0d) required (3,19)", cursor_x, cursor_y); else n_pass++;
    preload(1'b0);
    mx = 0;
    model_scroll();
    send(8'h0A);
    wait_idle(cyc);
    n_total++; if (cyc != 2360) $display("FAIL lf_scroll_busy got %0d cycles required 2360", cyc); else n_pass++;
    n_total++; if ({cursor_x, cursor_y} !== {6'd0, 5'd19}) $display("FAIL lf_cursor got (%0d,%0d) required (0,19)", cursor_x, cursor_y); else n_pass++;
    n_total++; if (char_ready !== 1'b1) $display("FAIL lf_ready got %b required 1", char_ready); else n_pass++;
    bad = 0;
    for (int i = 0; i < 800; i++)
      if (ram[i] !== ((i < 760) ? 8'(i + 40) : 8'h20)) bad++;
    n_total++; if (bad != 0) $display("FAIL lf_ram_cells got %0d wrong cells required 0", bad); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL lf_pending got %0d writes required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_scroll_wrap();
    int cyc;
    for (int i = 0; i < 39; i++) tb_char(8'h79);
    n_total++; if ({cursor_x, cursor_y} !== {6'd39, 5'd19}) $display("FAIL wrap19_setup got (%0d,%0d) required (39,19)", cursor_x, cursor_y); else n_pass++;
    exp_write(10'd799, 8'h41);
    mx = 0;
    model_scroll();
    send(8'h41);
    wait_idle(cyc);
    n_total++; if (cyc != 2362) $display("FAIL wrap19_busy got %0d cycles required 2362", cyc); else n_pass++;
    n_total++; if (ram[759] !== 8'h41) $display("FAIL wrap19_ram759 got %h required 41", ram[759]); else n_pass++;
    n_total++; if (ram[799] !== 8'h20) $display("FAIL wrap19_ram799 got %h required 20", ram[799]); else n_pass++;
    n_total++; if ({cursor_x, cursor_y} !== {6'd0, 5'd19}) $display("FAIL wrap19_cursor got (%0d,%0d) required (0,19)", cursor_x, cursor_y); else n_pass++;
  endtask

  task automatic test_clear();
    int cyc, w0, bad;
    preload(1'b1);
    w0 = wr_cnt;
    for (int i = 0; i < 800; i++) exp_write(10'(i), 8'h20);
    mx = 0; my = 0;
    send(8'h0C);
    wait_idle(cyc);
    n_total++; if (cyc != 1600) $display("FAIL ff_busy got %0d cycles required 1600", cyc); else n_pass++;
    n_total++; if (wr_cnt - w0 != 800) $display("FAIL ff_we_pulses got %0d required 800", wr_cnt - w0); else n_pass++;
    bad = 0;
    for (int i = 0; i < 800; i++) if (ram[i] !== 8'h20) bad++;
    n_total++; if (bad != 0) $display("FAIL ff_ram_cells got %0d wrong cells required 0", bad); else n_pass++;
    n_total++; if ({cursor_x, cursor_y} !== 11'd0) $display("FAIL ff_cursor got (%0d,%0d) required (0,0)", cursor_x, cursor_y); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int w0, w1;
    for (int i = 0; i < 19; i++) tb_char(8'h0A);
    w0 = wr_cnt;
    mx = 0;
    model_scroll();
    send(8'h0A);
    repeat (99) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    exp_q.delete();
    mx = 0; my = 0;
    n_total++; if ({mem_we, busy} !== 2'b00) $display("FAIL abort_we_busy got %b required 00", {mem_we, busy}); else n_pass++;
    n_total++; if ({cursor_x, cursor_y} !== 11'd0) $display("FAIL abort_cursor got (%0d,%0d) required (0,0)", cursor_x, cursor_y); else n_pass++;
    n_total++; if (char_ready !== 1'b1) $display("FAIL abort_ready got %b required 1", char_ready); else n_pass++;
    w1 = wr_cnt;
    n_total++; if (w1 - w0 != 33) $display("FAIL abort_partial got %0d writes required 33", w1 - w0); else n_pass++;
    repeat (50) @(negedge clk);
    n_total++; if (wr_cnt != w1) $display("FAIL abort_late_writes got %0d required 0", wr_cnt - w1); else n_pass++;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_back_to_back();
    test_wrap_and_ctrl();
    test_scroll_lf();
    test_scroll_wrap();
    test_clear();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
